// File: rtl/fetch_redirect_unit_if.sv
// rtl/fetch_redirect_unit_if.sv - fetch/redirect bus bundle: control inputs, imem port and IF/ID register outputs
// FETCH_STATS_EN adds the redirect/squash statistics counters to the bundle.
interface fetch_redirect_unit_if #(
   parameter int PC_W = 64
);
   logic             stall;
   logic             switch_branch;
   logic             Flush;
   logic [PC_W-1:0]  branch_target;
   logic [31:0]      imem_instr;
   logic [PC_W-1:0]  pc_out;
   logic             imem_en;
   logic [PC_W-1:0]  ifid_pc;
   logic [31:0]      ifid_instr;
   logic             ifid_valid;
`ifdef FETCH_STATS_EN
   logic [31:0]      redirect_count;
   logic [31:0]      squash_count;

   modport master (
      input  stall, switch_branch, Flush, branch_target, imem_instr,
      output pc_out, imem_en, ifid_pc, ifid_instr, ifid_valid,
      output redirect_count, squash_count
   );

   modport slave (
      output stall, switch_branch, Flush, branch_target, imem_instr,
      input  pc_out, imem_en, ifid_pc, ifid_instr, ifid_valid,
      input  redirect_count, squash_count
   );
`else
   modport master (
      input  stall, switch_branch, Flush, branch_target, imem_instr,
      output pc_out, imem_en, ifid_pc, ifid_instr, ifid_valid
   );

   modport slave (
      output stall, switch_branch, Flush, branch_target, imem_instr,
      input  pc_out, imem_en, ifid_pc, ifid_instr, ifid_valid
   );
`endif
endinterface

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC sequencing, branch redirect and IF/ID register with stale-fetch squash
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_redirect_unit #(
   parameter int              PC_W      = 64,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  reset,
   fetch_redirect_unit_if.master bus
);

   typedef enum logic {
      RUN,
      SQUASH
   } state_t;

   state_t           state;
   logic [PC_W-1:0]  fpc;
   logic             fetch_en;
   logic             advance;
   logic             load_bubble;

   // A redirect always fetches, even under stall, so its target is never lost.
   assign fetch_en    = ~bus.stall | bus.switch_branch;
   assign bus.imem_en = fetch_en;

   assign advance     = ~bus.switch_branch & ~bus.stall;
   assign load_bubble = ~bus.switch_branch & (bus.Flush | (advance & (state == SQUASH)));

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.pc_out     <= RESET_PC;
         fpc            <= RESET_PC;
         bus.ifid_pc    <= '0;
         bus.ifid_instr <= NOP_INSTR;
         bus.ifid_valid <= 1'b0;
         state          <= SQUASH;
      end else begin
         // fpc tags whatever word imem returns on the following cycle.
         if (fetch_en) begin
            fpc <= bus.pc_out;
         end

         if (bus.switch_branch) begin
            bus.pc_out     <= bus.branch_target;
            bus.ifid_pc    <= fpc;
            bus.ifid_instr <= NOP_INSTR;
            bus.ifid_valid <= 1'b0;
            state          <= SQUASH;
         end else begin
            if (advance) begin
               bus.pc_out <= bus.pc_out + PC_W'(4);
               state      <= RUN;
            end

            if (load_bubble) begin
               bus.ifid_pc    <= fpc;
               bus.ifid_instr <= NOP_INSTR;
               bus.ifid_valid <= 1'b0;
            end else if (advance) begin
               bus.ifid_pc    <= fpc;
               bus.ifid_instr <= bus.imem_instr;
               bus.ifid_valid <= 1'b1;
            end
         end
      end
   end

`ifdef FETCH_STATS_EN
   logic squash_evt;

   // Counts every IF/ID bubble caused by a pending squash or a Flush request.
   assign squash_evt = bus.Flush | load_bubble;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.redirect_count <= '0;
         bus.squash_count   <= '0;
      end else begin
         if (bus.switch_branch && (bus.redirect_count != 32'hFFFF_FFFF)) begin
            bus.redirect_count <= bus.redirect_count + 32'd1;
         end
         if (squash_evt && (bus.squash_count != 32'hFFFF_FFFF)) begin
            bus.squash_count <= bus.squash_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed self-checking bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

   localparam int          PC_W   = 64;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [63:0] RST_PC = 64'h0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_redirect_unit_if #(.PC_W(PC_W)) bus();

   fetch_redirect_unit #(
      .PC_W      (PC_W),
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] lo;
      lo = a[31:0];
      return lo ^ 32'hC0DE_0000;
   endfunction

   // Instruction memory: one-cycle read latency, output held while not enabled.
   always @(posedge clk) begin
      if (bus.imem_en) bus.imem_instr <= mem_word(bus.pc_out);
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: next fetch address, one in-flight fetch with a "trusted" flag, IF/ID contents.
   logic [63:0] m_pc, m_fl_addr, m_ifid_pc;
   bit          m_fl_ok, m_valid;
   logic [31:0] m_ifid_instr;
   logic [31:0] m_redir, m_squash;

   function automatic void m_bubble();
      m_valid      = 1'b0;
      m_ifid_instr = NOP;
   endfunction

   function automatic void m_sat_inc(inout logic [31:0] c);
      if (c != 32'hFFFF_FFFF) c = c + 1;
   endfunction

   function automatic void model_step();
      if (reset) begin
         m_pc = RST_PC; m_fl_addr = RST_PC; m_fl_ok = 1'b0;
         m_ifid_pc = '0; m_bubble();
         m_redir = '0; m_squash = '0;
      end else if (bus.switch_branch) begin
         m_sat_inc(m_redir);
         if (bus.Flush) m_sat_inc(m_squash);
         m_bubble();
         m_fl_addr = m_pc; m_fl_ok = 1'b0;
         m_pc = bus.branch_target;
      end else if (bus.stall) begin
         if (bus.Flush) begin
            m_bubble();
            m_sat_inc(m_squash);
         end
      end else begin
         if (m_fl_ok && !bus.Flush) begin
            m_valid = 1'b1; m_ifid_pc = m_fl_addr; m_ifid_instr = mem_word(m_fl_addr);
         end else begin
            m_bubble();
            m_sat_inc(m_squash);
         end
         m_fl_addr = m_pc; m_fl_ok = 1'b1;
         m_pc = m_pc + 64'd4;
      end
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("pc_out", bus.pc_out, m_pc);
         chk("imem_en", {63'd0, bus.imem_en}, {63'd0, (!bus.stall || bus.switch_branch)});
         chk("ifid_valid", {63'd0, bus.ifid_valid}, {63'd0, m_valid});
         chk("ifid_instr", {32'd0, bus.ifid_instr}, {32'd0, m_ifid_instr});
         if (m_valid) chk("ifid_pc", bus.ifid_pc, m_ifid_pc);
`ifdef FETCH_STATS_EN
         chk("redirect_count", {32'd0, bus.redirect_count}, {32'd0, m_redir});
         chk("squash_count", {32'd0, bus.squash_count}, {32'd0, m_squash});
`endif
      end
   end

   task automatic cyc(input bit rst, input bit st, input bit sb, input bit fl, input logic [63:0] tgt);
      reset = rst;
      bus.stall = st;
      bus.switch_branch = sb;
      bus.Flush = fl;
      bus.branch_target = tgt;
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic pin_valid(input string name, input logic [63:0] pc);
      chk({name, "_valid"}, {63'd0, bus.ifid_valid}, 64'd1);
      chk({name, "_pc"}, bus.ifid_pc, pc);
      chk({name, "_instr"}, {32'd0, bus.ifid_instr}, {32'd0, mem_word(pc)});
   endtask

   task automatic pin_bubble(input string name);
      chk({name, "_valid"}, {63'd0, bus.ifid_valid}, 64'd0);
      chk({name, "_instr"}, {32'd0, bus.ifid_instr}, {32'd0, NOP});
   endtask

   typedef struct {
      bit          st;
      bit          sb;
      bit          fl;
      logic [63:0] tgt;
   } vec_t;

   vec_t tbl[16] = '{
      '{1'b0, 1'b0, 1'b0, 64'h0},   '{1'b1, 1'b0, 1'b1, 64'h0},
      '{1'b0, 1'b1, 1'b0, 64'h800}, '{1'b1, 1'b0, 1'b0, 64'h0},
      '{1'b1, 1'b0, 1'b0, 64'h0},   '{1'b0, 1'b0, 1'b0, 64'h0},
      '{1'b0, 1'b0, 1'b1, 64'h0},   '{1'b0, 1'b1, 1'b1, 64'h900},
      '{1'b1, 1'b1, 1'b0, 64'hA00}, '{1'b0, 1'b0, 1'b0, 64'h0},
      '{1'b0, 1'b0, 1'b0, 64'h0},   '{1'b1, 1'b0, 1'b0, 64'h0},
      '{1'b0, 1'b0, 1'b1, 64'h0},   '{1'b0, 1'b0, 1'b0, 64'h0},
      '{1'b0, 1'b0, 1'b0, 64'h0},   '{1'b0, 1'b0, 1'b0, 64'h0}
   };

   initial begin
      logic [31:0] r0, s0;

      cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
      chk_on = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
      chk("rst_pc_out", bus.pc_out, 64'h0);
      pin_bubble("rst_ifid");

      // Reset release: first valid word is RESET_PC two cycles later.
      run(1);
      pin_bubble("rel1");
      chk("rel1_pc", bus.pc_out, 64'h4);
      run(1); pin_valid("rel2", 64'h0);
      run(1); pin_valid("rel3", 64'h4);
      run(1); pin_valid("rel4", 64'h8);
      run(1); pin_valid("rel5", 64'hC);
      run(3);
      chk("pre_redir_pc", bus.pc_out, 64'h20);

      // Redirect with Flush from 0x20 to 0x100.
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h100);
      chk("redir_pc", bus.pc_out, 64'h100);
      pin_bubble("redir_e0");
      run(1); pin_bubble("redir_e1");
      run(1); pin_valid("redir_e2", 64'h100);

      // Stall three cycles at pc_out=0x40.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h38);
      run(2);
      chk("stall_pre_pc", bus.pc_out, 64'h40);
      pin_valid("stall_pre", 64'h38);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
         chk("stall_pc", bus.pc_out, 64'h40);
         pin_valid("stall_hold", 64'h38);
      end
      run(1); pin_valid("stall_res0", 64'h3C);
      chk("stall_res_pc", bus.pc_out, 64'h44);
      run(1); pin_valid("stall_res1", 64'h40);

      // Flush alone, then Flush under stall.
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
      pin_bubble("flush");
      chk("flush_pc", bus.pc_out, 64'h4C);
      run(1); pin_valid("flush_after", 64'h48);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 64'd0);
      pin_bubble("flush_stall");
      chk("flush_stall_pc", bus.pc_out, 64'h50);
      run(1); pin_valid("flush_stall_after", 64'h4C);

      // Redirect wins over stall; pending squash survives the stall.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'h200);
      chk("redir_stall_pc", bus.pc_out, 64'h200);
      pin_bubble("redir_stall");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
      chk("sq_hold_pc", bus.pc_out, 64'h200);
      run(1); pin_bubble("sq_release");
      run(1); pin_valid("sq_after", 64'h200);

      // Back-to-back redirects.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h300);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h400);
      chk("b2b_pc", bus.pc_out, 64'h400);
      run(1); pin_bubble("b2b_e1");
      run(1); pin_valid("b2b_e2", 64'h400);

      // PC wraps modulo 2^64.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
      run(2);
      chk("wrap_pc", bus.pc_out, 64'h0);
      pin_valid("wrap_e2", 64'hFFFF_FFFF_FFFF_FFF8);
      run(1); pin_valid("wrap_e3", 64'hFFFF_FFFF_FFFF_FFFC);

      // Reset during stall, then during redirect.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'h500);
      chk("rst_stall_pc", bus.pc_out, 64'h0);
      pin_bubble("rst_stall");
      run(1); pin_bubble("rst_stall_e1");
      run(1); pin_valid("rst_stall_e2", 64'h0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'h600);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
      run(1); pin_bubble("rst_redir_e1");
      run(1); pin_valid("rst_redir_e2", 64'h0);

      foreach (tbl[i]) cyc(1'b0, tbl[i].st, tbl[i].sb, tbl[i].fl, tbl[i].tgt);
      run(3);

`ifdef FETCH_STATS_EN
      r0 = m_redir;
      s0 = m_squash;
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h100);
         run(2);
      end
      chk("stat_redirect", {32'd0, bus.redirect_count}, {32'd0, r0 + 32'd5});
      chk("stat_squash", {32'd0, bus.squash_count}, {32'd0, s0 + 32'd10});
`else
      r0 = '0;
      s0 = '0;
`endif

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_redirect_unit.md
FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 Parameter PC_W, default 64, program-counter width.
REQ-002 Parameter RESET_PC, default 0, PC loaded on reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, bubble instruction written into IF/ID.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hazard-unit hold request for PC and IF/ID.
REQ-007 switch_branch  input  1  taken-branch redirect from branch control.
REQ-008 Flush  input  1  IF/ID squash request from branch control.
REQ-009 branch_target  input  PC_W  redirect address, valid when switch_branch=1.
REQ-010 imem_instr  input  32  instruction-memory read data, 1-cycle latency after imem_en.
REQ-011 pc_out  output  PC_W  current fetch address to instruction memory.
REQ-012 imem_en  output  1  instruction-memory read enable.
REQ-013 ifid_pc  output  PC_W  PC of instruction held in IF/ID.
REQ-014 ifid_instr  output  32  instruction held in IF/ID.
REQ-015 ifid_valid  output  1  IF/ID holds a real (non-bubble) instruction.

Function
REQ-016 Priority per cycle SHALL be: reset > switch_branch > Flush > stall > normal advance.
REQ-017 imem_en SHALL equal ~stall | switch_branch; imem_instr SHALL be assumed held while imem_en=0.
REQ-018 Internal register fpc SHALL record pc_out whenever imem_en=1, tagging the instruction returning next cycle.
REQ-019 FSM states RUN and SQUASH; SQUASH discards the one in-flight stale fetch.
REQ-020 Normal advance (RUN, stall=0): pc_out <= pc_out+4 (mod 2^PC_W, wraps), ifid_pc <= fpc, ifid_instr <= imem_instr, ifid_valid <= 1.
REQ-021 Normal advance in SQUASH: pc_out <= pc_out+4, IF/ID <= {fpc, NOP_INSTR, valid 0}, state <= RUN.
REQ-022 switch_branch=1 (any state, stall ignored): pc_out <= branch_target, IF/ID <= bubble, state <= SQUASH.
REQ-023 Flush=1 with switch_branch=0: IF/ID <= bubble, pc_out and state follow stall/normal rules.
REQ-024 stall=1 without redirect/flush: pc_out, fpc, IF/ID and state SHALL hold; a pending SQUASH persists until stall drops.
REQ-025 Back-to-back switch_branch cycles: each redirect reloads pc_out and re-enters SQUASH; no stale instruction ever reaches ifid_valid=1.
REQ-026 Latency: first valid instruction from branch_target appears in IF/ID exactly 2 cycles after the redirect edge (absent stall).
REQ-027 branch_target SHALL be used unmodified; misalignment handling is out of scope.

Reset
REQ-028 On reset: pc_out=RESET_PC, fpc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, state=SQUASH, statistics counters=0.
REQ-029 Reset mid-redirect or mid-stall SHALL discard all pending state; first valid IF/ID entry is instruction at RESET_PC, 2 cycles after reset deasserts.

Configuration
REQ-030 Macro FETCH_STATS_EN defined: adds outputs redirect_count[31:0] (increments per cycle with switch_branch=1) and squash_count[31:0] (increments per cycle IF/ID is loaded with a bubble due to SQUASH or Flush), both saturating at 32'hFFFF_FFFF.
REQ-031 Macro FETCH_STATS_EN undefined: counters and their ports SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset release, RESET_PC=0, imem returns addr-encoded words -> ifid_valid first 1 at cycle 2 with ifid_pc=0, then ifid_pc 4, 8, 12 on consecutive cycles.
REQ-033 switch_branch=1, Flush=1, branch_target=0x100 while pc_out=0x20 -> next cycle pc_out=0x100, ifid_valid=0; following cycle ifid_valid=0 (stale 0x20 squashed); then ifid_pc=0x100, ifid_valid=1.
REQ-034 stall=1 for 3 cycles at pc_out=0x40 -> pc_out, ifid_pc, ifid_instr unchanged for 3 cycles, imem_en=0; advance resumes at 0x44 with no lost or duplicated instruction.
REQ-035 switch_branch asserted together with stall=1, target 0x200 -> redirect wins: pc_out=0x200 next cycle, IF/ID bubble.
REQ-036 switch_branch on two consecutive cycles, targets 0x300 then 0x400 -> pc_out=0x400, no instruction from 0x300 or prior becomes valid; ifid_pc=0x400 valid 2 cycles after second redirect.
REQ-037 FETCH_STATS_EN defined, scenario REQ-033 repeated 5 times -> redirect_count=5, squash_count=10.
